muldiv_unit: RTL

- HI/LO multiply-divide responder for the E stage of the five-stage MIPS pipeline.
- Accepts one mult/multu/div/divu/mthi/mtlo request per start pulse from Execute.
- Models fixed multi-cycle latency with a busy flag; Execute stalls on start|busy.
- Continuously drives the architectural HI/LO registers that mfhi/mflo read.

---
 rtl/muldiv_unit_pkg.sv | 23 ++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op codes, FSM states
// and default busy durations.
package muldiv_unit_pkg;

    // Operation codes driven by Execute on the op port.
    localparam logic [2:0] MD_OP_NONE  = 3'd0;
    localparam logic [2:0] MD_OP_MULT  = 3'd1;
    localparam logic [2:0] MD_OP_MULTU = 3'd2;
    localparam logic [2:0] MD_OP_DIV   = 3'd3;
    localparam logic [2:0] MD_OP_DIVU  = 3'd4;
    localparam logic [2:0] MD_OP_MTHI  = 3'd5;
    localparam logic [2:0] MD_OP_MTLO  = 3'd6;

    // Default busy durations in cycles.
    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit. The result is computed at the start edge and
// held in a pending register; it becomes architecturally visible when the
// fixed-latency countdown expires, the same edge busy falls.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;

    // Returns {hi, lo} for mult/multu/div/divu, including the divide-by-zero
    // and signed-overflow conventions.
    function automatic logic [63:0] md_compute(input logic [2:0]  f_op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sprod;
        logic signed [31:0] squot;
        logic signed [31:0] srem;
        logic [63:0]        res;
        sprod = '0;
        squot = '0;
        srem  = '0;
        res   = '0;
        case (f_op)
            MD_OP_MULT: begin
                sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                res   = sprod;
            end
            MD_OP_MULTU: res = {32'd0, a} * {32'd0, b};
            MD_OP_DIV: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    squot = $signed(a) / $signed(b);
                    srem  = $signed(a) % $signed(b);
                    res   = {srem, squot};
                end
            end
            MD_OP_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Next-state logic: accept requests in idle, count down and commit in run.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        MD_OP_MULT, MD_OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = md_compute(op, rs, rt);
                            cnt_d   = CntW'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = StRun;
                        end
                        MD_OP_DIV, MD_OP_DIVU: begin
                            {pend_hi_d, pend_lo_d} = md_compute(op, rs, rt);
                            cnt_d   = CntW'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = StRun;
                        end
                        MD_OP_MTHI: hi_d = rs;
                        MD_OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // Requests arriving here are dropped; Execute stalls on busy.
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous reset; reset discards any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;

endmodule
